// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: branch resolution, variable-latency data-memory access
// over a req/ack bus with stall/timeout handling, and the MEM/WB pipeline register.
module mem_stage_ctrl #(
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned CNT_W   = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc,
   input  logic [31:0] alu_out,
   input  logic [31:0] wdata,
   input  logic [4:0]  wn,
   input  logic [1:0]  control_W,
   input  logic        zero,
   input  logic        branch,
   input  logic        mem_write,
   input  logic        mem_read,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        pc_src,
   output logic [31:0] branch_target,
   output logic        stall,
   output logic [1:0]  out_W,
   output logic [31:0] out_rdata,
   output logic [31:0] out_alu,
   output logic [4:0]  out_wn,
   output logic        misalign,
   output logic        bus_err
);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_WAIT = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   count_q, count_d;

   logic [1:0]  out_W_q;
   logic [31:0] out_rdata_q;
   logic [31:0] out_alu_q;
   logic [4:0]  out_wn_q;
   logic        misalign_q;
   logic        bus_err_q;

   logic acc_req;
   logic aligned;
   logic access;
   logic misal;
   logic abort;
   logic complete;
   logic ld_done;

   assign pc_src        = branch & zero;
   assign branch_target = pc;
   assign mem_addr      = alu_out;
   assign mem_wdata     = wdata;
   assign mem_we        = mem_write;

   assign acc_req = mem_read | mem_write;
   assign aligned = (alu_out[1:0] == 2'b00);
   assign access  = acc_req & aligned;
   assign misal   = acc_req & ~aligned;

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      mem_req = 1'b0;
      abort   = 1'b0;
      case (state_q)
         S_IDLE: begin
            mem_req = access;
            count_d = '0;
            if (access && !mem_ack) begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            mem_req = 1'b1;
            if (mem_ack) begin
               state_d = S_IDLE;
               count_d = '0;
            end else if (count_q == CNT_W'(TIMEOUT - 1)) begin
               abort   = 1'b1;
               state_d = S_IDLE;
               count_d = '0;
            end else begin
               count_d = count_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            count_d = '0;
         end
      endcase
   end

   // A timed-out access releases the pipeline in the same cycle it is aborted.
   assign stall    = mem_req & ~mem_ack & ~abort;
   assign complete = mem_req & mem_ack;
   assign ld_done  = complete & mem_read & ~mem_write;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_W_q     <= '0;
         out_rdata_q <= '0;
         out_alu_q   <= '0;
         out_wn_q    <= '0;
         misalign_q  <= 1'b0;
         bus_err_q   <= 1'b0;
      end else begin
         if (stall) begin
            out_W_q <= '0;
         end else begin
            out_alu_q <= alu_out;
            out_wn_q  <= wn;
            if (ld_done) begin
               out_rdata_q <= mem_rdata;
            end
            out_W_q <= (abort || misal) ? 2'b00 : control_W;
         end
         if (misal) begin
            misalign_q <= 1'b1;
         end
         if (abort) begin
            bus_err_q <= 1'b1;
         end
      end
   end

   assign out_W     = out_W_q;
   assign out_rdata = out_rdata_q;
   assign out_alu   = out_alu_q;
   assign out_wn    = out_wn_q;
   assign misalign  = misalign_q;
   assign bus_err   = bus_err_q;

endmodule
